// File: rtl/regex_line_sequencer.sv
// Line sequencer for a bit-serial regex engine: accepts one WIDTH-bit line, resets the engine,
// streams the bits MSB first, waits for the engine to settle, then reports match/line number.
module regex_line_sequencer #(
  parameter int WIDTH      = 21,
  parameter int LINE_W     = 14,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_valid,
  input  logic [WIDTH-1:0]  line_data,
  output logic              line_ready,
  output logic              eng_rst,
  output logic              eng_i,
  output logic              eng_ic,
  input  logic              eng_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_match,
  output logic [LINE_W-1:0] res_line,
  output logic [15:0]       match_count,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Once raised, res_valid and its payload hold until that transfer; line_ready is only high in IDLE.

  localparam int CNT_W = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    SETTLE = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]   cnt;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      cnt         <= '0;
      line_ready  <= 1'b1;
      eng_rst     <= 1'b0;
      eng_i       <= 1'b0;
      eng_ic      <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_line    <= '0;
      match_count <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (line_valid && line_ready) begin
            shift_reg  <= line_data;
            res_line   <= res_line + LINE_W'(1);
            line_ready <= 1'b0;
            busy       <= 1'b1;
            eng_rst    <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          // The first bit is presented together with the SHIFT entry so SHIFT lasts exactly WIDTH cycles.
          eng_rst   <= 1'b0;
          eng_i     <= 1'b1;
          eng_ic    <= shift_reg[WIDTH-1];
          shift_reg <= shift_reg << 1;
          cnt       <= CNT_W'(WIDTH - 1);
          state     <= SHIFT;
        end
        SHIFT: begin
          if (cnt == '0) begin
            eng_ic <= 1'b0;
            cnt    <= CNT_W'(SETTLE_CYC - 1);
            state  <= SETTLE;
          end else begin
            eng_ic    <= shift_reg[WIDTH-1];
            shift_reg <= shift_reg << 1;
            cnt       <= cnt - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            res_match <= eng_o;
            eng_i     <= 1'b0;
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        REPORT: begin
          if (res_ready) begin
            if (res_match && (match_count != 16'hFFFF)) begin
              match_count <= match_count + 16'd1;
            end
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            line_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          line_ready <= 1'b1;
          eng_rst    <= 1'b0;
          eng_i      <= 1'b0;
          eng_ic     <= 1'b0;
          res_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regex_line_sequencer.sv
// Bench for regex_line_sequencer: default instance plus a LINE_W=2 / SETTLE_CYC=3 instance,
// each fed by a small bit-serial engine model that matches one target line.
module tb_regex_line_sequencer;
  localparam int W    = 21;
  localparam int LW   = 14;
  localparam int LW_B = 2;
  localparam int S_B  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          line_valid = 1'b0;
  logic [W-1:0]  line_data = '0;
  logic          line_ready, eng_rst, eng_i, eng_ic, eng_o;
  logic          res_valid, res_match, busy;
  logic          res_ready = 1'b1;
  logic [LW-1:0] res_line;
  logic [15:0]   match_count;
  logic [2:0]    state_dbg;

  logic            line_valid_b = 1'b0;
  logic [W-1:0]    line_data_b = '0;
  logic            line_ready_b, eng_rst_b, eng_i_b, eng_ic_b, eng_o_b;
  logic            res_valid_b, res_match_b, busy_b;
  logic            res_ready_b = 1'b1;
  logic [LW_B-1:0] res_line_b;
  logic [15:0]     match_count_b;
  logic [2:0]      state_dbg_b;

  regex_line_sequencer dut (
    .clk(clk), .reset(reset), .line_valid(line_valid), .line_data(line_data),
    .line_ready(line_ready), .eng_rst(eng_rst), .eng_i(eng_i), .eng_ic(eng_ic),
    .eng_o(eng_o), .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_line(res_line), .match_count(match_count), .busy(busy), .state_dbg(state_dbg)
  );

  regex_line_sequencer #(.WIDTH(W), .LINE_W(LW_B), .SETTLE_CYC(S_B)) dut_b (
    .clk(clk), .reset(reset), .line_valid(line_valid_b), .line_data(line_data_b),
    .line_ready(line_ready_b), .eng_rst(eng_rst_b), .eng_i(eng_i_b), .eng_ic(eng_ic_b),
    .eng_o(eng_o_b), .res_valid(res_valid_b), .res_ready(res_ready_b), .res_match(res_match_b),
    .res_line(res_line_b), .match_count(match_count_b), .busy(busy_b), .state_dbg(state_dbg_b)
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine models: collect the first W enabled bits after eng_rst; match only in the last settle cycle.
  logic [W-1:0] tgt_a = 21'h155555;
  logic [W-1:0] tgt_b = 21'h0F0F0F;
  logic [W-1:0] cap_a = '0, cap_b = '0;
  int n_a = 0, n_b = 0;

  always @(posedge clk) begin
    if (eng_rst) begin
      cap_a <= '0; n_a <= 0;
    end else if (eng_i) begin
      if (n_a < W) cap_a <= {cap_a[W-2:0], eng_ic};
      n_a <= n_a + 1;
    end
  end
  assign eng_o = (n_a == W) && (cap_a == tgt_a);

  always @(posedge clk) begin
    if (eng_rst_b) begin
      cap_b <= '0; n_b <= 0;
    end else if (eng_i_b) begin
      if (n_b < W) cap_b <= {cap_b[W-2:0], eng_ic_b};
      n_b <= n_b + 1;
    end
  end
  assign eng_o_b = (n_b == W + S_B - 1) && (cap_b == tgt_b);

  // scoreboard
  logic [LW:0]   exp_q[$];
  logic [LW_B:0] exp_qb[$];
  int            lines_a = 0, lines_b = 0;
  logic [15:0]   exp_mc_a = '0, exp_mc_b = '0;
  int unsigned   accept_cyc = 0, accept_cyc_b = 0;
  int            n_cmp = 0, n_fail = 0;

  // driver tasks (all entered and left on a falling edge)
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; line_valid = 1'b0; line_valid_b = 1'b0;
    res_ready = 1'b1; res_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lines_a = 0; lines_b = 0; exp_mc_a = '0; exp_mc_b = '0;
    exp_q.delete(); exp_qb.delete();
  endtask

  task automatic drive_a(input logic [W-1:0] data, output logic ok);
    int t = 0;
    ok = 1'b0;
    while (!line_ready && t < 100) begin @(negedge clk); t++; end
    if (line_ready) begin
      line_valid = 1'b1; line_data = data; accept_cyc = cyc + 1;
      lines_a++;
      exp_q.push_back({(data == tgt_a), LW'(lines_a)});
      @(negedge clk);
      line_valid = 1'b0; line_data = W'($urandom);
      ok = 1'b1;
    end
  endtask

  task automatic drive_b(input logic [W-1:0] data, output logic ok);
    int t = 0;
    ok = 1'b0;
    while (!line_ready_b && t < 100) begin @(negedge clk); t++; end
    if (line_ready_b) begin
      line_valid_b = 1'b1; line_data_b = data; accept_cyc_b = cyc + 1;
      lines_b++;
      exp_qb.push_back({(data == tgt_b), LW_B'(lines_b)});
      @(negedge clk);
      line_valid_b = 1'b0; line_data_b = W'($urandom);
      ok = 1'b1;
    end
  endtask

  task automatic wait_res_a(output logic got);
    int t = 0;
    while (!res_valid && t < 200) begin @(negedge clk); t++; end
    got = res_valid;
  endtask

  task automatic wait_res_b(output logic got);
    int t = 0;
    while (!res_valid_b && t < 200) begin @(negedge clk); t++; end
    got = res_valid_b;
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({line_ready, busy, res_valid, res_match, eng_rst, eng_i, eng_ic} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 1000000",
               {line_ready, busy, res_valid, res_match, eng_rst, eng_i, eng_ic});
    end
    n_cmp++;
    if ({res_line, match_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got line=%0d count=%0d expected 0/0", res_line, match_count);
    end
    n_cmp++;
    if ({line_ready_b, busy_b, res_valid_b, res_line_b} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_b: got %b expected 10000", {line_ready_b, busy_b, res_valid_b, res_line_b});
    end
  endtask

  task automatic test_reset_mid_shift();
    logic ok, seen;
    logic [LW:0] e;
    apply_reset();
    drive_a(tgt_a, ok);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); lines_a = 0; exp_mc_a = '0;
    n_cmp++;
    if ({ok, busy, eng_i, line_ready, res_valid} !== 5'b10010) begin
      n_fail++;
      $display("FAIL abort_idle: got ok,busy,eng_i,ready,valid=%b expected 10010",
               {ok, busy, eng_i, line_ready, res_valid});
    end
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (res_valid) seen = 1'b1; end
    n_cmp++;
    if ({seen, match_count} !== 17'd0) begin
      n_fail++;
      $display("FAIL abort_no_result: got valid_seen=%b count=%0d expected 0/0", seen, match_count);
    end
    drive_a(21'h000123, ok);
    wait_res_a(seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || !seen || {res_match, res_line} !== e || res_line !== LW'(1)) begin
      n_fail++;
      $display("FAIL abort_next_line: got match=%b line=%0d expected match=%b line=%0d",
               res_match, res_line, e[LW], e[LW-1:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic ok, got, en_ok;
    logic [W-1:0] seq;
    logic [LW:0] e;
    apply_reset();
    drive_a(21'h155555, ok);
    n_cmp++;
    if ({ok, eng_rst, eng_i} !== 3'b110) begin
      n_fail++;
      $display("FAIL clear_cycle: got ok,eng_rst,eng_i=%b expected 110", {ok, eng_rst, eng_i});
    end
    seq = '0; en_ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      seq = {seq[W-2:0], eng_ic};
      if (!eng_i || eng_rst) en_ok = 1'b0;
    end
    n_cmp++;
    if (seq !== 21'h155555 || !en_ok) begin
      n_fail++;
      $display("FAIL shift_bits: got %h enable_ok=%b expected 155555/1", seq, en_ok);
    end
    @(negedge clk);
    n_cmp++;
    if ({eng_i, eng_ic, res_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL settle_cycle: got eng_i,eng_ic,valid=%b expected 100", {eng_i, eng_ic, res_valid});
    end
    wait_res_a(got);
    n_cmp++;
    if (!got || (cyc - accept_cyc) != 23) begin
      n_fail++;
      $display("FAIL latency: got valid=%b after %0d edges expected 1 after 23", got, cyc - accept_cyc);
    end
    e = exp_q.pop_front();
    exp_mc_a = exp_mc_a + 16'(e[LW]);
    n_cmp++;
    if ({res_match, res_line} !== e) begin
      n_fail++;
      $display("FAIL single_result: got match=%b line=%0d expected match=%b line=%0d",
               res_match, res_line, e[LW], e[LW-1:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (match_count !== exp_mc_a || {res_valid, line_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_count: got count=%0d valid,ready=%b expected %0d/01",
               match_count, {res_valid, line_ready}, exp_mc_a);
    end
  endtask

  task automatic test_back_to_back();
    logic ok, got;
    logic [LW:0] e;
    logic [W-1:0] lines [3];
    int unsigned acc [3];
    lines[0] = tgt_a; lines[1] = 21'h0ABCDE; lines[2] = tgt_a;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_a(lines[i], ok);
      acc[i] = accept_cyc;
      wait_res_a(got);
      e = exp_q.pop_front();
      exp_mc_a = exp_mc_a + 16'(e[LW]);
      n_cmp++;
      if (!ok || !got || {res_match, res_line} !== e) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got match=%b line=%0d expected match=%b line=%0d",
                 i, res_match, res_line, e[LW], e[LW-1:0]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (match_count !== exp_mc_a || exp_mc_a !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 2", match_count);
    end
    n_cmp++;
    if ((acc[1] - acc[0]) != 25 || (acc[2] - acc[1]) != 25) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d,%0d expected 25,25", acc[1] - acc[0], acc[2] - acc[1]);
    end
  endtask

  task automatic test_stall();
    logic ok, got, stable;
    logic [LW:0] e;
    logic [LW+1:0] snap;
    apply_reset();
    drive_a(tgt_a, ok);
    wait_res_a(got);
    e = exp_q.pop_front();
    res_ready = 1'b0;
    snap = {res_valid, res_match, res_line};
    stable = ok & got;
    for (int i = 0; i < 10; i++) begin
      line_valid = 1'b1; line_data = W'($urandom);
      @(negedge clk);
      if ({res_valid, res_match, res_line} !== snap || line_ready !== 1'b0 || match_count !== 16'd0)
        stable = 1'b0;
    end
    line_valid = 1'b0;
    n_cmp++;
    if (!stable) begin
      n_fail++;
      $display("FAIL stall_hold: got valid,match,line=%b ready=%b count=%0d expected %b/0/0",
               {res_valid, res_match, res_line}, line_ready, match_count, snap);
    end
    n_cmp++;
    if ({res_valid, res_match, res_line} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL stall_result: got match=%b line=%0d expected match=%b line=%0d",
               res_match, res_line, e[LW], e[LW-1:0]);
    end
    res_ready = 1'b1;
    exp_mc_a = exp_mc_a + 16'(e[LW]);
    @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (match_count !== exp_mc_a || {res_valid, busy, line_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL stall_release: got count=%0d valid,busy,ready=%b expected %0d/001",
               match_count, {res_valid, busy, line_ready}, exp_mc_a);
    end
  endtask

  task automatic test_small_instance();
    logic ok, got;
    logic [LW_B:0] e;
    logic [W-1:0] lines [5];
    logic [LW_B-1:0] want [5];
    lines[0] = tgt_b; lines[1] = 21'h1FFFFF; lines[2] = tgt_b; lines[3] = 21'h000001; lines[4] = tgt_b;
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0; want[4] = 2'd1;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_b(lines[i], ok);
      wait_res_b(got);
      if (i == 0) begin
        n_cmp++;
        if (!got || (cyc - accept_cyc_b) != 25 || res_match_b !== 1'b1) begin
          n_fail++;
          $display("FAIL settle3_latency: got valid=%b edges=%0d match=%b expected 1/25/1",
                   got, cyc - accept_cyc_b, res_match_b);
        end
      end
      e = exp_qb.pop_front();
      exp_mc_b = exp_mc_b + 16'(e[LW_B]);
      n_cmp++;
      if (!ok || !got || {res_match_b, res_line_b} !== e || res_line_b !== want[i]) begin
        n_fail++;
        $display("FAIL wrap_result[%0d]: got match=%b line=%0d expected match=%b line=%0d",
                 i, res_match_b, res_line_b, e[LW_B], want[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (match_count_b !== exp_mc_b) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d expected %0d", match_count_b, exp_mc_b);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_single();
    test_back_to_back();
    test_stall();
    test_small_instance();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regex_line_sequencer.md
REGEX_LINE_SEQUENCER -- requirements
Module: regex_line_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 21, bits per input line.
REQ-002 SHALL have parameter LINE_W, default 14, line-number width.
REQ-003 SHALL have parameter SETTLE_CYC, default 1, engine settle cycles after last bit (legal 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port line_valid  input  1  line word offered.
REQ-007 SHALL have port line_data  input  WIDTH  line bits; MSB is sent first.
REQ-008 SHALL have port line_ready  output  1  sequencer can accept a line.
REQ-009 SHALL have port eng_rst  output  1  reset pulse to the regex engine.
REQ-010 SHALL have port eng_i  output  1  engine enable/start bit.
REQ-011 SHALL have port eng_ic  output  1  serial character bit to the engine.
REQ-012 SHALL have port eng_o  input  1  engine match output.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  result consumer ready.
REQ-015 SHALL have port res_match  output  1  latched eng_o for the reported line.
REQ-016 SHALL have port res_line  output  LINE_W  1-based number of the reported line.
REQ-017 SHALL have port match_count  output  16  total matched lines since reset.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, SHIFT, SETTLE, REPORT.
REQ-020 IDLE: line_ready=1; on line_valid&line_ready, capture line_data into a WIDTH-bit shift register and go to CLEAR.
REQ-021 line_ready SHALL be 0 in every state other than IDLE; line_data is not sampled outside an accept.
REQ-022 CLEAR: eng_rst=1 for exactly one cycle, bit counter loaded with WIDTH-1, next state SHIFT.
REQ-023 SHIFT: eng_i=1, eng_ic=shift-register MSB, shift left one bit per cycle; exactly WIDTH cycles; counter 0 -> SETTLE.
REQ-024 SETTLE: eng_i=1, eng_ic=0, lasts SETTLE_CYC cycles; eng_o sampled into res_match on the last SETTLE edge; next REPORT.
REQ-025 REPORT: res_valid=1, res_match/res_line stable until res_valid&res_ready; on that edge go to IDLE.
REQ-026 eng_rst, eng_i, eng_ic SHALL be 0 in IDLE and REPORT.
REQ-027 Latency: res_valid SHALL rise 1+WIDTH+SETTLE_CYC rising edges after the accept edge (23 for defaults).
REQ-028 Minimum line period SHALL be WIDTH+SETTLE_CYC+3 cycles (25 for defaults) with res_ready held high.
REQ-029 res_line SHALL equal the count of lines accepted since reset including the current one (first line = 1), wrapping modulo 2^LINE_W.
REQ-030 match_count SHALL increment by 1 on each REPORT handshake with res_match=1, saturating at 16'hFFFF.
REQ-031 res_ready low in REPORT SHALL stall indefinitely with all outputs held and no new line accepted.
REQ-032 line_valid asserted during a non-IDLE state SHALL be ignored and held off by line_ready=0.

Reset
REQ-033 On reset: state IDLE, line_ready=1 on the following cycle, busy=0, res_valid=0, res_match=0, res_line=0, match_count=0, eng_rst=0, eng_i=0, eng_ic=0, shift register and counters cleared.
REQ-034 Reset asserted in any state SHALL abort the line in progress with no result and no count update; reset has priority over every handshake.

Verification
REQ-035 Single line 21'h155555, engine model matching -> eng_ic sequence 1,0,1,0,...,1 over 21 cycles; eng_rst one cycle before; res_valid at edge 23; res_match=1; res_line=1; match_count=1.
REQ-036 Three back-to-back lines, res_ready tied 1, engine matches lines 1 and 3 -> accepts spaced 25 cycles; res_line 1,2,3; res_match 1,0,1; match_count=2.
REQ-037 res_ready held 0 for 10 cycles in REPORT -> res_valid/res_line/res_match stable, line_ready=0, single handshake, match_count increments once.
REQ-038 Reset asserted on the 10th SHIFT cycle -> next cycle IDLE, eng_i=0, no res_valid, match_count unchanged; next line reports res_line=1.
REQ-039 LINE_W=2, five lines -> res_line 1,2,3,0,1.
REQ-040 SETTLE_CYC=3, eng_o rising only in the last SETTLE cycle -> res_match=1, res_valid at edge 25 after accept.
